// File: rtl/days_if.sv
// days_if - bundle between the day-of-month counter and its neighbours.
//   Parameter YEAR_W : width of the year field (0..99 within the century).
//   master : drives mode/setup controls, hour carry, tick, month and year;
//            samples day and done_day.
//   slave  : the days counter itself.
interface days_if #(
  parameter int YEAR_W = 7
);
  logic              display;      // 0 = run, 1 = setup/display
  logic              setup_day;    // active-low day-field select
  logic              inc_dec_day;  // 1 = increment, 0 = decrement
  logic              done_hour;    // one-cycle carry from hours
  logic              tick;         // one-cycle setup strobe
  logic [5:0]        month;        // 1..12 from month counter
  logic [YEAR_W-1:0] year;         // year within century
  logic [5:0]        day;          // current day, 1..31
  logic              done_day;     // one-cycle carry to month counter

  modport master (
    output display, setup_day, inc_dec_day, done_hour, tick, month, year,
    input  day, done_day
  );

  modport slave (
    input  display, setup_day, inc_dec_day, done_hour, tick, month, year,
    output day, done_day
  );
endinterface

// File: rtl/days.sv
// days - day-of-month counter between the hours and month counters.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset (day=1, done_day=0)
//   bus  : days_if.slave (mode/setup controls, done_hour, tick, month, year
//          in; day, done_day out)
// Optional build macro: LEAP_YEAR_EN - February has 29 days when
// year[1:0]==0 (year 00 included). Without it February is always 28 and
// the year field is ignored, though still present on the interface.
module days #(
  parameter int YEAR_W = 7
) (
  input  logic   clk,
  input  logic   rst,
  days_if.slave  bus
);

  logic [5:0]        day_q, day_d;
  logic              done_q, done_d;
  logic [5:0]        last;
  logic [YEAR_W-1:0] year_q;

  assign year_q = bus.year;

  // February length depends on the build.
  logic [5:0] feb_len;
`ifdef LEAP_YEAR_EN
  assign feb_len = (year_q[1:0] == 2'b00) ? 6'd29 : 6'd28;
`else
  logic unused_year;
  assign unused_year = ^year_q;
  assign feb_len     = 6'd28;
`endif

  // Month length; out-of-range months fall back to 31.
  always_comb begin
    last = 6'd31;
    case (bus.month)
      6'd2:                         last = feb_len;
      6'd4, 6'd6, 6'd9, 6'd11:      last = 6'd30;
      default:                      last = 6'd31;
    endcase
  end

  // Next state: clamp first so a shortened month never shows an illegal
  // day, then run-mode carry, then setup editing.
  always_comb begin
    day_d  = day_q;
    done_d = 1'b0;
    if (day_q > last) begin
      day_d = last;
    end else if (!bus.display) begin
      if (bus.done_hour) begin
        if (day_q == last) begin
          day_d  = 6'd1;
          done_d = 1'b1;
        end else begin
          day_d = day_q + 6'd1;
        end
      end
    end else if (!bus.setup_day && bus.tick) begin
      if (day_q == 6'd0)
        day_d = 6'd1;
      else if (bus.inc_dec_day)
        day_d = (day_q == last) ? 6'd1 : day_q + 6'd1;
      else
        day_d = (day_q == 6'd1) ? last : day_q - 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      day_q  <= 6'd1;
      done_q <= 1'b0;
    end else begin
      day_q  <= day_d;
      done_q <= done_d;
    end
  end

  assign bus.day      = day_q;
  assign bus.done_day = done_q;

endmodule

// File: tb/tb_days.sv
// tb_days - directed and randomized check of the days counter against a
// calendar-level reference model.
module tb_days;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  days_if #(.YEAR_W(7)) bus ();

  days #(.YEAR_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: calendar day and carry flag.
  int mdl_day  = 1;
  int mdl_done = 0;

  function automatic int month_len(int m, int y);
    bit leap;
`ifdef LEAP_YEAR_EN
    leap = (y % 4) == 0;
`else
    leap = 1'b0;
`endif
    if (m == 2)                                return leap ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: advance the model from the current inputs, clock the DUT,
  // then compare day and done_day.
  task automatic step(input string tag);
    int last;
    last = month_len(int'(bus.month), int'(bus.year));
    if (rst) begin
      mdl_day = 1; mdl_done = 0;
    end else if (mdl_day > last) begin
      mdl_day = last; mdl_done = 0;
    end else if (!bus.display) begin
      mdl_done = 0;
      if (bus.done_hour) begin
        if (mdl_day == last) begin mdl_day = 1; mdl_done = 1; end
        else mdl_day = mdl_day + 1;
      end
    end else begin
      mdl_done = 0;
      if (!bus.setup_day && bus.tick) begin
        if (bus.inc_dec_day) mdl_day = (mdl_day % last) + 1;
        else                 mdl_day = (mdl_day == 1) ? last : mdl_day - 1;
      end
    end
    @(posedge clk);
    #1;
    chk({tag, ".day"},  {2'b00, bus.day}, 8'(mdl_day));
    chk({tag, ".done"}, {7'd0, bus.done_day}, 8'(mdl_done));
  endtask

  task automatic idle_inputs();
    rst = 1'b0;
    bus.display = 1'b0; bus.setup_day = 1'b1; bus.inc_dec_day = 1'b1;
    bus.done_hour = 1'b0; bus.tick = 1'b0;
  endtask

  // Walk the day to a target with setup decrement ticks (bounded).
  task automatic set_day(input int target);
    bus.display = 1'b1; bus.setup_day = 1'b0; bus.inc_dec_day = 1'b0;
    bus.done_hour = 1'b0; bus.tick = 1'b1;
    for (int i = 0; i < 40 && mdl_day != target; i++) step("set_day");
    idle_inputs();
    chk("set_day.reach", {2'b00, bus.day}, 8'(target));
  endtask

  initial begin
    idle_inputs();
    bus.month = 6'd1; bus.year = 7'd23;

    // Reset dominates live carry and tick.
    rst = 1'b1; bus.done_hour = 1'b1; bus.tick = 1'b1;
    bus.display = 1'b1; bus.setup_day = 1'b0;
    step("reset0"); step("reset1");
    idle_inputs();

    // Run wrap at end of a 30-day month, carry for exactly one cycle.
    bus.month = 6'd4;
    set_day(30);
    bus.done_hour = 1'b1; step("wrap30");
    bus.done_hour = 1'b0; step("wrap30_after");

    // Day 30 of a 31-day month advances without carry.
    bus.month = 6'd1;
    set_day(30);
    bus.done_hour = 1'b1; step("jan30");
    bus.done_hour = 1'b0;

    // Back-to-back hour carries across a wrap.
    bus.month = 6'd4;
    set_day(29);
    bus.done_hour = 1'b1;
    step("b2b_a"); step("b2b_b"); step("b2b_c");
    idle_inputs();

    // February, leap-candidate year then ordinary year.
    bus.month = 6'd2; bus.year = 7'd24;
    step("feb_clamp24");
    set_day(28);
    bus.done_hour = 1'b1; step("feb24"); bus.done_hour = 1'b0; step("feb24_after");
    bus.year = 7'd23;
    step("feb23_clamp");
    set_day(28);
    bus.done_hour = 1'b1; step("feb23"); bus.done_hour = 1'b0; step("feb23_after");

    // Setup wrap both directions, then deselected field.
    bus.month = 6'd6;
    set_day(30);
    bus.display = 1'b1; bus.setup_day = 1'b0; bus.tick = 1'b1;
    bus.inc_dec_day = 1'b1; step("setup_inc_wrap");
    bus.inc_dec_day = 1'b0; step("setup_dec_wrap");
    bus.setup_day = 1'b1;   step("setup_desel");
    bus.setup_day = 1'b0; bus.tick = 1'b0; step("setup_notick");
    idle_inputs();

    // Clamp on month edit, and clamp beating a carry.
    bus.month = 6'd1; set_day(31);
    bus.month = 6'd9; step("clamp_sep");
    bus.month = 6'd1; set_day(31);
    bus.month = 6'd9; bus.done_hour = 1'b1; step("clamp_vs_hour");
    bus.done_hour = 1'b0;
    bus.month = 6'd1; set_day(31);
    bus.month = 6'd2; bus.year = 7'd23; step("clamp_feb");
    bus.month = 6'd0; step("bad_month");

    // Reset on the same edge as a wrapping carry: no carry out.
    bus.month = 6'd4; set_day(30);
    bus.done_hour = 1'b1; rst = 1'b1; step("rst_vs_wrap");
    idle_inputs(); step("rst_after");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rst             = ($urandom_range(0, 49) == 0);
      bus.display     = $urandom_range(0, 1);
      bus.setup_day   = ($urandom_range(0, 3) == 0);
      bus.inc_dec_day = $urandom_range(0, 1);
      bus.done_hour   = ($urandom_range(0, 2) != 0);
      bus.tick        = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) bus.month = 6'($urandom_range(0, 13));
      if ($urandom_range(0, 7) == 0) bus.year  = 7'($urandom_range(0, 99));
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
